// File: rtl/combi_hazard_ctrl.sv
// Hazard and ISA-mode controller for the combined ARM/RISC-V five-stage core.
// Resolves forwarding, load-use stalls, redirects and the drain before an ISA switch.

module combi_hazard_fwd #(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] i_rs,
  input  logic [REGW-1:0] i_rd_m,
  input  logic [REGW-1:0] i_rd_w,
  input  logic            i_we_m,
  input  logic            i_we_w,
  input  logic            i_arm,
  output logic [1:0]      o_fwd
);
  logic w_hit_m, w_hit_w;

  // r0 is hardwired zero in RISC-V but a real register in ARM
  assign w_hit_m = i_we_m && (i_rd_m == i_rs) && (i_arm || (i_rd_m != '0));
  assign w_hit_w = i_we_w && (i_rd_w == i_rs) && (i_arm || (i_rd_w != '0));

  always_comb begin
    o_fwd = 2'b00;
    if (w_hit_m)      o_fwd = 2'b10;
    else if (w_hit_w) o_fwd = 2'b01;
  end
endmodule

module combi_hazard_ctrl #(
  parameter int REGW         = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter bit RESET_ARM    = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            armD,
  input  logic            armE,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] Rs1E,
  input  logic [REGW-1:0] Rs2E,
  input  logic [REGW-1:0] RdE,
  input  logic [REGW-1:0] RdM,
  input  logic [REGW-1:0] RdW,
  input  logic            ResultSrcE0,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            PCSrcE,
  output logic            armIn,
  output logic            wasNotFlushed,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            switching
);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  logic [0:0] r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_mode, w_mode_nxt;
  logic       r_wnf, w_wnf_nxt;
  logic       w_stall, w_flush_d, w_flush_e;
  logic       w_lw_stall, w_mode_change;

  logic [1:0][REGW-1:0] w_rs_e;
  logic [1:0][1:0]      w_fwd;

  assign w_rs_e = {Rs2E, Rs1E};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_fwd
      combi_hazard_fwd #(.REGW(REGW)) u_fwd (
        .i_rs   (w_rs_e[g]),
        .i_rd_m (RdM),
        .i_rd_w (RdW),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .i_arm  (armE),
        .o_fwd  (w_fwd[g])
      );
    end
  endgenerate

  // Bubbles in D are qualified out so a flushed slot never stalls or switches mode
  assign w_lw_stall    = ResultSrcE0 && ((RdE == Rs1D) || (RdE == Rs2D)) && r_wnf;
  assign w_mode_change = r_wnf && (armD != r_mode);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_stall     = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (PCSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
          w_stall   = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_mode_change) begin
          w_stall     = 1'b1;
          w_flush_e   = 1'b1;
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_DRAIN: begin
        if (PCSrcE) begin
          // redirect kills the switching instruction; mode stays as it was
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_stall   = 1'b1;
          w_flush_e = 1'b1;
          if (r_cnt == 4'd0) begin
            w_mode_nxt  = armD;
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_wnf_nxt = 1'b1;
    if (w_flush_d)    w_wnf_nxt = 1'b0;
    else if (w_stall) w_wnf_nxt = r_wnf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
      r_mode  <= RESET_ARM;
      r_wnf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_wnf   <= w_wnf_nxt;
    end
  end

  // While reset is held the pipeline registers are forced to bubbles
  assign armIn         = r_mode;
  assign wasNotFlushed = r_wnf;
  assign StallF        = reset & w_stall;
  assign StallD        = reset & w_stall;
  assign FlushD        = ~reset | w_flush_d;
  assign FlushE        = ~reset | w_flush_e;
  assign ForwardAE     = reset ? w_fwd[0] : 2'b00;
  assign ForwardBE     = reset ? w_fwd[1] : 2'b00;
  assign switching     = reset & (r_state == S_DRAIN);
endmodule

// File: doc/combi_hazard_ctrl.md
Name: combi_hazard_ctrl

Overview:
Pipeline hazard and ISA-mode controller for the combined ARM/RISC-V five-stage core. It generates stall, flush and forwarding controls around the shared decoder and ALU. It owns the committed ISA-mode register that drives the decoder's armIn, and the wasNotFlushed flag. On an ISA change it sequences a drain so that no older instruction executes under the wrong mode.

Parameters:
REGW, 5, register-address width; ARM 4-bit addresses are zero-extended.
DRAIN_CYCLES, 3, bubble cycles inserted before a mode switch commits; legal range 1..15.
RESET_ARM, 0, ISA mode after reset (0 = RISC-V, 1 = ARM).

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
armD  in  1  decoder's ISA classification of the instruction in D
armE  in  1  ISA mode of the instruction in E
Rs1D, Rs2D  in  REGW  source registers in D
Rs1E, Rs2E, RdE  in  REGW  source and destination registers in E
RdM, RdW  in  REGW  destination registers in M and W
ResultSrcE0  in  1  E holds a load
RegWriteM, RegWriteW  in  1  M and W write the register file
PCSrcE  in  1  redirect (taken branch, jump, or ARM PC write) resolved in E
armIn  out  1  committed ISA mode, fed to the decoder
wasNotFlushed  out  1  D holds a real (non-bubble) instruction
StallF, StallD  out  1  hold the PC and the IF/ID register
FlushD, FlushE  out  1  bubble the IF/ID and ID/EX registers
ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result
switching  out  1  FSM is in DRAIN

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state=RUN, modeQ=RESET_ARM, cnt=0, wnfQ=0.
  - Outputs: armIn=RESET_ARM, wasNotFlushed=0, StallF=StallD=0, FlushD=FlushE=1, Forward*=00, switching=0.
- armIn=modeQ and wasNotFlushed=wnfQ, both registered.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM & RdM==Rs1E & (armE | RdM!=0).
  - Otherwise ForwardAE=01 if RegWriteW & RdW==Rs1E & (armE | RdW!=0).
  - Otherwise ForwardAE=00.
  - M has priority over W. Register 0 is never forwarded in RISC-V mode; it is a real register in ARM mode.
  - ForwardBE uses the same rules with Rs2E.
- lwStall = ResultSrcE0 & (RdE==Rs1D | RdE==Rs2D) & wnfQ.
- modeChange = wnfQ & (armD != modeQ).
- State RUN, priority PCSrcE > lwStall > modeChange:
  - PCSrcE: FlushD=FlushE=1, no stall; stay in RUN.
  - lwStall: StallF=StallD=1, FlushE=1; one bubble per cycle while the condition holds.
  - modeChange: go to DRAIN, cnt=DRAIN_CYCLES-1, StallF=StallD=1, FlushE=1.
  - Otherwise all controls are 0.
- State DRAIN:
  - StallF=StallD=1, FlushE=1, switching=1.
  - If PCSrcE: abort. FlushD=FlushE=1, stalls=0, go to RUN, modeQ unchanged.
  - Else if cnt==0: modeQ<=armD, go to RUN. Stalls stay asserted this cycle; D issues under the new mode on the next cycle.
  - Else: cnt<=cnt-1.
- wnfQ update, evaluated at each clock edge:
  - 0 if FlushD.
  - Held if StallD.
  - 1 otherwise.
- A flush in the same cycle as modeChange: the flush wins and DRAIN is not entered.
- modeChange is never raised when wnfQ=0, because the decoder returns armIn on flushed slots.
- Reset asserted mid-DRAIN: return to RUN immediately with modeQ=RESET_ARM.
- Total stall for a mode switch is DRAIN_CYCLES+1 cycles.
- Arithmetic: cnt is 4 bits, decrements only, never wraps.

Test Plan:
1. Reset: hold reset=0, then release. Required: FlushD=FlushE=1 during reset; armIn=RESET_ARM; wasNotFlushed=0, then 1 after the first non-stalled edge with no flush.
2. Forwarding priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=5 -> ForwardAE=10. With RdM=0, RdW=0, Rs1E=0, armE=0 -> 00. Same with armE=1 -> 10.
3. Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> exactly one cycle of StallF=StallD=FlushE=1; ForwardBE=01 on the following cycle.
4. Mode switch: modeQ=0, armD=1, wnfQ=1, DRAIN_CYCLES=3 -> switching=1 for 3 cycles, stalls for 4 cycles, armIn=1 after the last stall edge.
5. Abort: same setup as scenario 4, with PCSrcE=1 in the second DRAIN cycle -> FlushD=FlushE=1, state RUN, armIn stays 0, wasNotFlushed=0 on the next cycle.
6. Simultaneous events: PCSrcE=1, lwStall and modeChange in the same cycle -> flush only, no stall, switching=0. Then pulse reset=0 mid-DRAIN -> immediate return to RUN.
